// File: rtl/learn_sequencer_pkg.sv
// Shared definitions for the 20-tap online bit predictor: sizes, FSM state
// encodings, led field positions and small arithmetic helpers.
package learn_sequencer_pkg;

    localparam int N     = 20;   // history length / weight count
    localparam int W     = 10;   // weight width, signed Q4.5
    localparam int ACC_W = 15;   // dot-product accumulator width (|sum| <= 10240)
    localparam int SQ_W  = 23;   // sum-of-squares width
    localparam int IDX_W = 5;    // tap index width

    localparam logic [IDX_W-1:0] IDX_LAST = 5'd19;

    // led field positions
    localparam int LED_PRED     = 7;
    localparam int LED_READY    = 6;
    localparam int LED_HITS_MSB = 5;
    localparam int LED_HITS_LSB = 0;

    // Saturation bounds expressed at the width of the update sum
    localparam logic signed [2*W:0] SUM_MAX = 21'sd511;
    localparam logic signed [2*W:0] SUM_MIN = -21'sd512;

    typedef enum logic [2:0] {
        ST_PRED  = 3'd0,
        ST_DONE  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_UPD   = 3'd3,
        ST_NORM  = 3'd4,
        ST_SCALE = 3'd5,
        ST_SHIFT = 3'd6
    } state_t;

    // Bipolar map: bit 0 -> +1, bit 1 -> -1
    function automatic logic signed [W-1:0] s_of(input logic b);
        if (b) begin
            return -10'sd1;
        end else begin
            return 10'sd1;
        end
    endfunction

    // Clamp a widened update sum back into the weight range [-512, 511]
    function automatic logic signed [W-1:0] sat_w(input logic signed [2*W:0] v);
        if (v > SUM_MAX) begin
            return 10'sd511;
        end else if (v < SUM_MIN) begin
            return -10'sd512;
        end else begin
            return v[W-1:0];
        end
    endfunction

endpackage

// File: rtl/learn_sequencer_key_debounce.sv
// Key debouncer: 2-FF synchroniser, DEBOUNCE_CYC-cycle stability counter and
// a one-cycle pulse on an accepted high->low (press) transition.
// The debounced level resets to "pressed" (0), so a key held through reset
// produces no event until it is released and pressed again; a released key
// simply debounces up to 1 after reset without producing an event.
module learn_sequencer_key_debounce
    import learn_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic press_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       sync_r;
    logic             stable_r;
    logic [CNT_W-1:0] cnt_r;
    logic             pulse_r;

    // Synchronise, count consecutive differing samples, accept and pulse on press
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r   <= 2'b00;
            stable_r <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            pulse_r  <= 1'b0;
        end else begin
            sync_r  <= {sync_r[0], key_raw};
            pulse_r <= 1'b0;
            if (sync_r[1] != stable_r) begin
                if (cnt_r == CNT_LAST) begin
                    stable_r <= sync_r[1];
                    cnt_r    <= {CNT_W{1'b0}};
                    pulse_r  <= ~sync_r[1];
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else begin
                cnt_r <= {CNT_W{1'b0}};
            end
        end
    end

    assign press_pulse = pulse_r;

endmodule

// File: rtl/learn_sequencer.sv
// Online bit predictor sequencer: serial dot product of weights against the
// bipolar history, signed weight update on a miss, optional gamma
// renormalisation, then history shift. led = {pred_bit, ready, hits[5:0]}.
// Optional feature macro: GAMMA_NORM_EN (adds the NORM/SCALE states).
module learn_sequencer
    import learn_sequencer_pkg::*;
#(
    parameter int ETA          = 32,      // update step in raw LSBs, must fit in W signed bits
    parameter int DEBOUNCE_CYC = 500000,
    parameter int NORM_LIMIT   = 20000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       k1,
    input  logic       k2,
    output logic [7:0] led
);

    localparam logic signed [W-1:0] ETA_S = $signed(ETA[W-1:0]);

    state_t                   state_r;
    state_t                   state_nxt;
    logic [IDX_W-1:0]         idx_r;
    logic signed [W-1:0]      w_r [N];
    logic [N-1:0]             hist_r;
    logic signed [ACC_W-1:0]  acc_r;
    logic                     pred_bit_r;
    logic                     ready_r;
    logic [5:0]               hits_r;
    logic                     in_bit_r;

    logic                     k1_ev_s;
    logic                     k2_ev_s;
    logic                     one_ev_s;
    logic                     idx_last_s;
    logic [IDX_W-1:0]         idx_step_s;
    logic signed [W-1:0]      w_cur_s;
    logic signed [W-1:0]      mul_a_s;
    logic signed [W-1:0]      mul_b_s;
    logic signed [2*W-1:0]    prod_s;
    logic signed [ACC_W-1:0]  acc_nxt_s;
    logic signed [2*W:0]      upd_sum_s;
    logic signed [W-1:0]      w_upd_s;

`ifdef GAMMA_NORM_EN
    localparam logic [SQ_W-1:0] NORM_LIM_S = NORM_LIMIT[SQ_W-1:0];
    logic [SQ_W-1:0]          sumsq_r;
    logic [SQ_W-1:0]          sumsq_nxt_s;
    logic                     norm_over_s;
`endif

    learn_sequencer_key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_k1 (
        .clk         (CLOCK_50),
        .reset       (reset),
        .key_raw     (k1),
        .press_pulse (k1_ev_s)
    );

    learn_sequencer_key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_k2 (
        .clk         (CLOCK_50),
        .reset       (reset),
        .key_raw     (k2),
        .press_pulse (k2_ev_s)
    );

    // Simultaneous k1/k2 events cancel each other; k1 means input bit 1
    assign one_ev_s   = k1_ev_s ^ k2_ev_s;
    assign idx_last_s = (idx_r == IDX_LAST);
    assign idx_step_s = idx_last_s ? {IDX_W{1'b0}} : idx_r + 5'd1;
    assign w_cur_s    = w_r[idx_r];

    // The single shared W x W multiplier
    assign prod_s     = mul_a_s * mul_b_s;
    assign acc_nxt_s  = acc_r + $signed(prod_s[ACC_W-1:0]);
    assign upd_sum_s  = $signed({{(W+1){w_cur_s[W-1]}}, w_cur_s}) + $signed({prod_s[2*W-1], prod_s});
    assign w_upd_s    = sat_w(upd_sum_s);

`ifdef GAMMA_NORM_EN
    assign sumsq_nxt_s = sumsq_r + {{(SQ_W-2*W){1'b0}}, prod_s};
    assign norm_over_s = (sumsq_nxt_s > NORM_LIM_S);
`endif

    // FSM state register
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r <= ST_PRED;
        end else begin
            state_r <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_PRED: begin
                if (idx_last_s) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_PRED;
                end
            end
            ST_DONE: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (one_ev_s) begin
                    if (k1_ev_s == pred_bit_r) begin
                        state_nxt = ST_SHIFT;
                    end else begin
                        state_nxt = ST_UPD;
                    end
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_UPD: begin
                if (idx_last_s) begin
`ifdef GAMMA_NORM_EN
                    state_nxt = ST_NORM;
`else
                    state_nxt = ST_SHIFT;
`endif
                end else begin
                    state_nxt = ST_UPD;
                end
            end
`ifdef GAMMA_NORM_EN
            ST_NORM: begin
                if (idx_last_s) begin
                    if (norm_over_s) begin
                        state_nxt = ST_SCALE;
                    end else begin
                        state_nxt = ST_SHIFT;
                    end
                end else begin
                    state_nxt = ST_NORM;
                end
            end
            ST_SCALE: begin
                if (idx_last_s) begin
                    state_nxt = ST_SHIFT;
                end else begin
                    state_nxt = ST_SCALE;
                end
            end
`endif
            ST_SHIFT: begin
                state_nxt = ST_PRED;
            end
            default: begin
                state_nxt = ST_PRED;
            end
        endcase
    end

    // FSM outputs: multiplier operand selection per serial state
    always_comb begin
        mul_a_s = w_cur_s;
        mul_b_s = s_of(hist_r[idx_r]);
        case (state_r)
            ST_PRED: begin
                mul_a_s = w_cur_s;
                mul_b_s = s_of(hist_r[idx_r]);
            end
            ST_UPD: begin
                // s*t is +1 when history bit and input bit agree
                mul_a_s = ETA_S;
                mul_b_s = s_of(hist_r[idx_r] ^ in_bit_r);
            end
`ifdef GAMMA_NORM_EN
            ST_NORM: begin
                mul_a_s = w_cur_s;
                mul_b_s = w_cur_s;
            end
`endif
            default: begin
                mul_a_s = w_cur_s;
                mul_b_s = s_of(hist_r[idx_r]);
            end
        endcase
    end

    // Datapath: accumulator, weights, history, score and status flags
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            idx_r      <= {IDX_W{1'b0}};
            hist_r     <= {N{1'b0}};
            acc_r      <= {ACC_W{1'b0}};
            pred_bit_r <= 1'b0;
            ready_r    <= 1'b0;
            hits_r     <= 6'd0;
            in_bit_r   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                w_r[i] <= {W{1'b0}};
            end
`ifdef GAMMA_NORM_EN
            sumsq_r    <= {SQ_W{1'b0}};
`endif
        end else begin
            case (state_r)
                ST_PRED: begin
                    acc_r <= acc_nxt_s;
                    idx_r <= idx_step_s;
                end
                ST_DONE: begin
                    pred_bit_r <= acc_r[ACC_W-1];
                    ready_r    <= 1'b1;
                end
                ST_WAIT: begin
                    if (one_ev_s) begin
                        ready_r  <= 1'b0;
                        in_bit_r <= k1_ev_s;
                        if ((k1_ev_s == pred_bit_r) && (hits_r != 6'd63)) begin
                            hits_r <= hits_r + 6'd1;
                        end
                    end
                end
                ST_UPD: begin
                    w_r[idx_r] <= w_upd_s;
                    idx_r      <= idx_step_s;
`ifdef GAMMA_NORM_EN
                    sumsq_r    <= {SQ_W{1'b0}};
`endif
                end
`ifdef GAMMA_NORM_EN
                ST_NORM: begin
                    sumsq_r <= sumsq_nxt_s;
                    idx_r   <= idx_step_s;
                end
                ST_SCALE: begin
                    w_r[idx_r] <= w_cur_s >>> 1;
                    idx_r      <= idx_step_s;
                end
`endif
                ST_SHIFT: begin
                    hist_r <= {hist_r[N-2:0], in_bit_r};
                    acc_r  <= {ACC_W{1'b0}};
                    idx_r  <= {IDX_W{1'b0}};
                end
                default: begin
                    idx_r <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    assign led[LED_PRED]                  = pred_bit_r;
    assign led[LED_READY]                 = ready_r;
    assign led[LED_HITS_MSB:LED_HITS_LSB] = hits_r;

endmodule

// File: tb/tb_learn_sequencer.sv
// Directed self-checking bench for learn_sequencer (DEBOUNCE_CYC = 4).
// A second instance with ETA = 300 reaches the weight clamp in two misses.
module tb_learn_sequencer;
    import learn_sequencer_pkg::*;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       k1, k2, k1b, k2b;
    logic [7:0] led, led_b;
    logic       sel_b;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state for the ETA = 32 instance
    int           mw [N];
    logic [N-1:0] mh;
    int           mhits;

    always #10 CLOCK_50 = ~CLOCK_50;

    learn_sequencer #(.ETA(32), .DEBOUNCE_CYC(4), .NORM_LIMIT(20000)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .k1       (k1),
        .k2       (k2),
        .led      (led)
    );

    learn_sequencer #(.ETA(300), .DEBOUNCE_CYC(4), .NORM_LIMIT(20000)) dut_b (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .k1       (k1b),
        .k2       (k2b),
        .led      (led_b)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int m_pred();
        int acc;
        acc = 0;
        for (int i = 0; i < N; i++) begin
            acc += mh[i] ? -mw[i] : mw[i];
        end
        return (acc < 0) ? 1 : 0;
    endfunction

    function automatic int m_led();
        return (m_pred() << 7) | 64 | mhits;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) mw[i] = 0;
        mh    = '0;
        mhits = 0;
    endtask

    // Apply one press of bit b to the model; returns expected fall-to-ready cycles
    task automatic m_press(input int b, output int lat);
        int t, s, v, sq;
        if (b == m_pred()) begin
            if (mhits < 63) mhits++;
            lat = N + 2;
        end else begin
            t = (b != 0) ? -1 : 1;
            for (int i = 0; i < N; i++) begin
                s = mh[i] ? -1 : 1;
                v = mw[i] + 32 * s * t;
                if (v > 511) v = 511;
                if (v < -512) v = -512;
                mw[i] = v;
            end
            lat = 2 * N + 2;
`ifdef GAMMA_NORM_EN
            sq = 0;
            for (int i = 0; i < N; i++) sq += mw[i] * mw[i];
            lat += N;
            if (sq > 20000) begin
                for (int i = 0; i < N; i++) mw[i] = mw[i] >>> 1;
                lat += N;
            end
`endif
        end
        mh = {mh[N-2:0], b[0]};
    endtask

    task automatic chk_weights(input string tag);
        for (int i = 0; i < N; i++) chk(tag, dut.w_r[i], mw[i]);
    endtask

    // a1/a2 = 1 presses k1/k2 of the selected instance; the other instance idles
    task automatic set_keys(input logic a1, input logic a2);
        if (sel_b) begin
            k1b = ~a1; k2b = ~a2; k1 = 1'b1; k2 = 1'b1;
        end else begin
            k1 = ~a1; k2 = ~a2; k1b = 1'b1; k2b = 1'b1;
        end
    endtask

    function automatic logic ready_sel();
        return sel_b ? led_b[6] : led[6];
    endfunction

    // Press (bit b, or both keys), release after 8 cycles; lat = cycles from
    // ready falling to ready rising, -1 if that never completed within budget
    task automatic press(input int b, input bit both, input int budget, output int lat);
        bit seen_low;
        int n;
        seen_low = 1'b0;
        n = 0;
        lat = -1;
        if (both) set_keys(1'b1, 1'b1);
        else      set_keys(b == 1, b == 0);
        for (int c = 0; c < budget; c++) begin
            @(negedge CLOCK_50);
            if (c == 8) set_keys(1'b0, 1'b0);
            if (!seen_low) begin
                if (!ready_sel()) begin
                    seen_low = 1'b1;
                    n = 0;
                end
            end else if (lat < 0) begin
                n++;
                if (ready_sel()) lat = n;
            end
            if (lat >= 0 && c >= 16) break;
        end
        set_keys(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (21) @(negedge CLOCK_50);
        chk("boot_ready", led, 8'h40);
        m_reset();
    endtask

    int  lat, elat, b;
    bit  found;

    initial begin
        reset = 1'b1;
        sel_b = 1'b0;
        k1 = 1'b1; k2 = 1'b1; k1b = 1'b1; k2b = 1'b1;
        m_reset();

        // reset state and boot latency
        repeat (3) @(negedge CLOCK_50);
        chk("rst_led", led, 8'h00);
        chk("rst_state", dut.state_r, ST_PRED);
        chk("rst_idx", dut.idx_r, 0);
        reset = 1'b0;
        repeat (20) @(negedge CLOCK_50);
        chk("boot_20", led, 8'h00);
        @(negedge CLOCK_50);
        chk("boot_21", led, 8'h40);

        // hit on k2 from reset
        press(0, 1'b0, 150, lat);
        m_press(0, elat);
        chk("hit_lat", lat, 22);
        chk("hit_led", led, 8'h41);
        chk("hit_hist", dut.hist_r, 0);
        chk_weights("hit_w");

        // miss on k1 from reset
        do_reset();
        press(1, 1'b0, 150, lat);
        m_press(1, elat);
`ifdef GAMMA_NORM_EN
        chk("miss_lat", lat, 82);
        for (int i = 0; i < N; i++) chk("miss_w", dut.w_r[i], -16);
`else
        chk("miss_lat", lat, 42);
        for (int i = 0; i < N; i++) chk("miss_w", dut.w_r[i], -32);
`endif
        chk("miss_led", led, 8'hC0);
        chk("miss_hist", dut.hist_r, 1);

        // 30 consecutive misses, each press the opposite of the model prediction
        for (int k = 0; k < 30; k++) begin
            b = 1 - m_pred();
            m_press(b, elat);
            press(b, 1'b0, 200, lat);
            chk("mis30_lat", lat, elat);
            chk("mis30_led", led, m_led());
            chk_weights("mis30_w");
        end

        // 2-cycle glitch on k1: no event
        k1 = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        k1 = 1'b1;
        repeat (20) @(negedge CLOCK_50);
        chk("glitch_led", led, m_led());
        chk("glitch_state", dut.state_r, ST_WAIT);

        // k1 and k2 together: both dropped
        press(0, 1'b1, 40, lat);
        chk("both_lat", lat, -1);
        chk("both_led", led, m_led());
        chk("both_state", dut.state_r, ST_WAIT);
        chk_weights("both_w");

        // second key pressed while in UPD is dropped
        b = 1 - m_pred();
        m_press(b, elat);
        set_keys(b == 1, b == 0);
        found = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge CLOCK_50);
            if (!led[6]) begin
                found = 1'b1;
                break;
            end
        end
        chk("upd_fall", found, 1);
        set_keys(b == 0, b == 1);
        repeat (10) @(negedge CLOCK_50);
        chk("upd_state", dut.state_r, ST_UPD);
        set_keys(1'b0, 1'b0);
        found = 1'b0;
        for (int c = 0; c < 150; c++) begin
            @(negedge CLOCK_50);
            if (led[6]) begin
                found = 1'b1;
                break;
            end
        end
        chk("upd_ready", found, 1);
        repeat (20) @(negedge CLOCK_50);
        chk("upd_led", led, m_led());
        chk("upd_state2", dut.state_r, ST_WAIT);
        chk_weights("upd_w");

        // reset asserted during UPD at idx 7
        b = 1 - m_pred();
        set_keys(b == 1, b == 0);
        found = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge CLOCK_50);
            if (dut.state_r == ST_UPD && dut.idx_r == 5'd7) begin
                found = 1'b1;
                break;
            end
        end
        chk("upd7_seen", found, 1);
        set_keys(1'b0, 1'b0);
        reset = 1'b1;
        @(negedge CLOCK_50);
        chk("abort_led", led, 8'h00);
        chk("abort_state", dut.state_r, ST_PRED);
        chk("abort_idx", dut.idx_r, 0);
        chk("abort_hist", dut.hist_r, 0);
        for (int i = 0; i < N; i++) chk("abort_w", dut.w_r[i], 0);
        reset = 1'b0;
        repeat (21) @(negedge CLOCK_50);
        chk("abort_boot", led, 8'h40);

        // ETA = 300 instance: second miss drives tap 0 into the clamp
        do_reset();
        sel_b = 1'b1;
        press(1, 1'b0, 150, lat);
`ifdef GAMMA_NORM_EN
        chk("b1_lat", lat, 82);
        chk("b1_w0", dut_b.w_r[0], -150);
`else
        chk("b1_lat", lat, 42);
        chk("b1_w0", dut_b.w_r[0], -300);
`endif
        chk("b1_led", led_b, 8'hC0);
        press(0, 1'b0, 150, lat);
`ifdef GAMMA_NORM_EN
        chk("b2_lat", lat, 82);
        chk("b2_w0", dut_b.w_r[0], -225);
        chk("b2_w1", dut_b.w_r[1], 75);
        chk("b2_led", led_b, 8'h40);
`else
        chk("b2_lat", lat, 42);
        chk("b2_w0", dut_b.w_r[0], -512);
        chk("b2_w1", dut_b.w_r[1], 0);
        chk("b2_led", led_b, 8'hC0);
`endif
        sel_b = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
